instr_fetch: RTL and testbench

- Instruction fetch and prefetch stage directly upstream of the instruction decoder.
- Fetches 64-bit instruction words from memory over a req/ack handshake and buffers them in a small prefetch FIFO.
- Presents the head word as dc[64:1] together with the half selector tkk; the decoder turns these into ir/op/addr.
- The sequencer steps through left/right halves with advance and redirects the fetch stream with flush.

---
 rtl/instr_fetch_pkg.sv | 24 ++
 rtl/instr_fetch_if.sv | 16 +
 rtl/instr_fetch_fifo.sv | 46 ++++
 rtl/instr_fetch.sv | 93 +++++++++
 tb/tb_instr_fetch.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_pkg.sv
// fetch_pkg: shared widths, fetch FSM states and the prefetch entry layout for instr_fetch.
// Optional byte-parity helper is built only with FETCH_PARITY_EN.
package fetch_pkg;
    localparam int WORD_W = 64;
    localparam int AW_DEF = 15;

    typedef enum logic [1:0] {IDLE, RUN, DROP} fetch_state_e;

    typedef struct packed {
        logic [WORD_W:1] word;
        logic [AW_DEF-1:0] addr;
        logic perr;
    } fetch_entry_t;

`ifdef FETCH_PARITY_EN
    // Odd parity per byte; p[i] covers w[8*i+8:8*i+1].
    function automatic logic par_err(logic [WORD_W:1] w, logic [7:0] p);
        logic e;
        e = 1'b0;
        for (int i = 0; i < 8; i++) e |= ~^{w[8*i+1 +: 8], p[i]};
        return e;
    endfunction
`endif
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction memory read port (req/ack handshake).
// Carries mem_rpar only when FETCH_PARITY_EN is defined.
interface instr_fetch_if import fetch_pkg::*; #(parameter int AW = AW_DEF);
    logic mem_req;
    logic [AW-1:0] mem_addr;
    logic mem_ack;
    logic [WORD_W:1] mem_rdata;
`ifdef FETCH_PARITY_EN
    logic [7:0] mem_rpar;
    modport master(output mem_req, mem_addr, input mem_ack, mem_rdata, mem_rpar);
    modport slave(input mem_req, mem_addr, output mem_ack, mem_rdata, mem_rpar);
`else
    modport master(output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave(input mem_req, mem_addr, output mem_ack, mem_rdata);
`endif
endinterface

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO (power-of-two DEPTH); clear beats push,
// and a full FIFO accepts a push when a pop happens in the same cycle.
module fetch_fifo import fetch_pkg::*; #(
    parameter type T = fetch_entry_t,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic push_i,
    input  logic pop_i,
    input  T din_i,
    output T head_o,
    output logic [PW:0] count_o
);
    T mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [PW:0] cnt_q;
    logic wr, rd;

    assign rd = pop_i & (cnt_q != '0);
    assign wr = push_i & ((cnt_q != (PW+1)'(DEPTH)) | rd);
    assign head_o = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            rd_q <= '0;
            wr_q <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) begin
                mem_q[wr_q] <= din_i;
                wr_q <= wr_q + 1'b1;
            end
            if (rd) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (PW+1)'(wr) - (PW+1)'(rd);
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch/prefetch stage feeding the decoder with dc/tkk/pc.
// Define FETCH_PARITY_EN to add per-byte read parity checking and the perr output.
module instr_fetch import fetch_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic [AW-1:0] jump_addr,
    input  logic jump_right,
    input  logic advance,
    instr_fetch_if.master mem,
    output logic [WORD_W:1] dc,
    output logic tkk,
    output logic valid,
    output logic [AW-1:0] pc
`ifdef FETCH_PARITY_EN
    , output logic perr
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WORD_W:1] word;
        logic [AW-1:0] addr;
`ifdef FETCH_PARITY_EN
        logic perr;
`endif
    } entry_t;

    fetch_state_e state_q;
    logic [AW-1:0] faddr_q, tgt_q;
    logic req_q, tkk_q;
    logic ack, push, pop;
    logic [CW-1:0] cnt, cnt_nxt;
    entry_t din, head;

    assign ack = mem.mem_ack & req_q;
    assign push = (state_q == RUN) & ack & ~flush;
    assign pop = advance & valid & tkk_q & ~flush;
    assign cnt_nxt = cnt + CW'(push) - CW'(pop);

    assign din.word = mem.mem_rdata;
    assign din.addr = faddr_q;
`ifdef FETCH_PARITY_EN
    assign din.perr = par_err(mem.mem_rdata, mem.mem_rpar);
    assign perr = valid & head.perr;
`endif

    fetch_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .clr_i(flush), .push_i(push), .pop_i(pop),
        .din_i(din), .head_o(head), .count_o(cnt)
    );

    assign mem.mem_req = req_q;
    assign mem.mem_addr = faddr_q;
    assign dc = head.word;
    assign pc = head.addr;
    assign valid = cnt != '0;
    assign tkk = tkk_q;

    // An unacked request must stay on the bus, so a flush then parks in DROP with the target latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            faddr_q <= '0;
            tgt_q <= '0;
            req_q <= 1'b0;
            tkk_q <= 1'b0;
        end else if (flush) begin
            tkk_q <= jump_right;
            if (req_q & ~mem.mem_ack) begin
                state_q <= DROP;
                tgt_q <= jump_addr;
            end else begin
                state_q <= RUN;
                faddr_q <= jump_addr;
                req_q <= 1'b1;
            end
        end else begin
            if (advance & valid) tkk_q <= ~tkk_q;
            if (state_q == DROP && ack) begin
                state_q <= RUN;
                faddr_q <= tgt_q;
                req_q <= 1'b1;
            end else if (state_q == RUN && !(req_q && !mem.mem_ack)) begin
                if (ack) faddr_q <= faddr_q + 1'b1;
                req_q <= int'(cnt_nxt) < DEPTH;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table plus hand sequences for DROP, flush+ack, wrap and parity.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic clk, rst_n, flush, jump_right, advance, ack_en;
    logic [14:0] jump_addr;
    logic [64:1] dc;
    logic tkk, valid;
    logic [14:0] pc;
    int total, bad;

    instr_fetch_if #(.AW(15)) mem_if();

    function automatic logic [64:1] word_of(logic [14:0] a);
        return 64'h0123456789ABCDEF + 64'(a) - 64'o100;
    endfunction

    assign mem_if.mem_ack = ack_en & mem_if.mem_req;
    assign mem_if.mem_rdata = word_of(mem_if.mem_addr);

`ifdef FETCH_PARITY_EN
    logic perr;
    logic [7:0] good_par;
    always_comb begin
        good_par = '0;
        for (int i = 0; i < 8; i++) good_par[i] = ~^mem_if.mem_rdata[8*i+1 +: 8];
    end
    assign mem_if.mem_rpar = good_par ^ ((mem_if.mem_addr == 15'o401) ? 8'h08 : 8'h00);
`endif

    instr_fetch #(.AW(15), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .jump_addr(jump_addr),
        .jump_right(jump_right), .advance(advance), .mem(mem_if.master),
        .dc(dc), .tkk(tkk), .valid(valid), .pc(pc)
`ifdef FETCH_PARITY_EN
        , .perr(perr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic fl, input logic [14:0] ja, input logic jr, input logic adv, input logic ack);
        flush = fl;
        jump_addr = ja;
        jump_right = jr;
        advance = adv;
        ack_en = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [14:0] addr, input logic vld, input logic t, input logic [14:0] p);
        chk({tag, ".req"}, 64'(mem_if.mem_req), 64'(req));
        chk({tag, ".addr"}, 64'(mem_if.mem_addr), 64'(addr));
        chk({tag, ".valid"}, 64'(valid), 64'(vld));
        chk({tag, ".tkk"}, 64'(tkk), 64'(t));
        if (vld) begin
            chk({tag, ".pc"}, 64'(pc), 64'(p));
            chk({tag, ".dc"}, dc, word_of(p));
        end
    endtask

    typedef struct {
        logic fl;
        logic [14:0] ja;
        logic jr, adv, ack;
        logic req;
        logic [14:0] addr;
        logic vld, t;
        logic [14:0] p;
    } vec_t;

    vec_t vt [16];

    initial begin
        total = 0;
        bad = 0;
        vt[0]  = '{1'b1, 15'o100, 1'b0, 1'b0, 1'b1, 1'b1, 15'o100, 1'b0, 1'b0, 15'o0};
        vt[1]  = '{1'b0, 15'o0, 1'b0, 1'b0, 1'b1, 1'b1, 15'o101, 1'b1, 1'b0, 15'o100};
        vt[2]  = '{1'b0, 15'o0, 1'b0, 1'b1, 1'b1, 1'b0, 15'o102, 1'b1, 1'b1, 15'o100};
        vt[3]  = '{1'b0, 15'o0, 1'b0, 1'b1, 1'b1, 1'b1, 15'o102, 1'b1, 1'b0, 15'o101};
        vt[4]  = '{1'b0, 15'o0, 1'b0, 1'b1, 1'b1, 1'b0, 15'o103, 1'b1, 1'b1, 15'o101};
        vt[5]  = '{1'b0, 15'o0, 1'b0, 1'b1, 1'b1, 1'b1, 15'o103, 1'b1, 1'b0, 15'o102};
        vt[6]  = '{1'b0, 15'o0, 1'b0, 1'b0, 1'b1, 1'b0, 15'o104, 1'b1, 1'b0, 15'o102};
        vt[7]  = '{1'b0, 15'o0, 1'b0, 1'b0, 1'b1, 1'b0, 15'o104, 1'b1, 1'b0, 15'o102};
        vt[8]  = '{1'b0, 15'o0, 1'b0, 1'b1, 1'b1, 1'b0, 15'o104, 1'b1, 1'b1, 15'o102};
        vt[9]  = '{1'b0, 15'o0, 1'b0, 1'b1, 1'b1, 1'b1, 15'o104, 1'b1, 1'b0, 15'o103};
        vt[10] = '{1'b1, 15'o7777, 1'b1, 1'b0, 1'b0, 1'b1, 15'o104, 1'b0, 1'b1, 15'o0};
        vt[11] = '{1'b0, 15'o0, 1'b0, 1'b1, 1'b0, 1'b1, 15'o104, 1'b0, 1'b1, 15'o0};
        vt[12] = '{1'b0, 15'o0, 1'b0, 1'b0, 1'b0, 1'b1, 15'o104, 1'b0, 1'b1, 15'o0};
        vt[13] = '{1'b0, 15'o0, 1'b0, 1'b0, 1'b1, 1'b1, 15'o7777, 1'b0, 1'b1, 15'o0};
        vt[14] = '{1'b0, 15'o0, 1'b0, 1'b0, 1'b1, 1'b1, 15'o10000, 1'b1, 1'b1, 15'o7777};
        vt[15] = '{1'b0, 15'o0, 1'b0, 1'b1, 1'b1, 1'b1, 15'o10001, 1'b1, 1'b0, 15'o10000};

        rst_n = 1'b0;
        flush = 1'b0;
        jump_addr = '0;
        jump_right = 1'b0;
        advance = 1'b0;
        ack_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 15'o0, 1'b0, 1'b0, 15'o0);
        chk("reset.pc", 64'(pc), 64'd0);
        chk("reset.dc", dc, 64'd0);
`ifdef FETCH_PARITY_EN
        chk("reset.perr", 64'(perr), 64'd0);
`endif
        rst_n = 1'b1;
        cyc(1'b0, 15'o0, 1'b0, 1'b0, 1'b1);
        chk_out("idle", 1'b0, 15'o0, 1'b0, 1'b0, 15'o0);

        for (int i = 0; i < 16; i++) begin
            cyc(vt[i].fl, vt[i].ja, vt[i].jr, vt[i].adv, vt[i].ack);
            chk_out($sformatf("vec%0d", i), vt[i].req, vt[i].addr, vt[i].vld, vt[i].t, vt[i].p);
        end

        // flush + advance in an ack cycle: acked word dropped, then wrap past 0o77777
        cyc(1'b1, 15'o77777, 1'b1, 1'b1, 1'b1);
        chk_out("flush_ack", 1'b1, 15'o77777, 1'b0, 1'b1, 15'o0);
        cyc(1'b0, 15'o0, 1'b0, 1'b0, 1'b1);
        chk_out("wrap0", 1'b1, 15'o0, 1'b1, 1'b1, 15'o77777);
        cyc(1'b0, 15'o0, 1'b0, 1'b1, 1'b1);
        chk_out("wrap1", 1'b1, 15'o1, 1'b1, 1'b0, 15'o0);

        // second flush during DROP replaces the latched target
        cyc(1'b1, 15'o300, 1'b0, 1'b0, 1'b0);
        chk_out("drop0", 1'b1, 15'o1, 1'b0, 1'b0, 15'o0);
        cyc(1'b1, 15'o400, 1'b0, 1'b0, 1'b0);
        chk_out("drop1", 1'b1, 15'o1, 1'b0, 1'b0, 15'o0);
        cyc(1'b0, 15'o0, 1'b0, 1'b0, 1'b1);
        chk_out("drop2", 1'b1, 15'o400, 1'b0, 1'b0, 15'o0);
        cyc(1'b0, 15'o0, 1'b0, 1'b0, 1'b1);
        chk_out("drop3", 1'b1, 15'o401, 1'b1, 1'b0, 15'o400);

`ifdef FETCH_PARITY_EN
        chk("par.good", 64'(perr), 64'd0);
        cyc(1'b0, 15'o0, 1'b0, 1'b0, 1'b1);
        chk("par.good_q", 64'(perr), 64'd0);
        cyc(1'b0, 15'o0, 1'b0, 1'b1, 1'b1);
        chk("par.right", 64'(perr), 64'd0);
        cyc(1'b0, 15'o0, 1'b0, 1'b1, 1'b1);
        chk("par.pc", 64'(pc), 64'(15'o401));
        chk("par.bad", 64'(perr), 64'd1);
        cyc(1'b1, 15'o500, 1'b0, 1'b0, 1'b1);
        chk("par.flush", 64'(perr), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
